sos_morse_player: RTL and testbench
===================================

// Module: sos_morse_player
// PURPOSE
//  Downstream consumer of the 3 s SOS enable pulse (SOS_En_Sig). Each accepted pulse plays one
//  Morse "SOS" (... --- ...) on a single output pin driving an LED or buzzer, then signals completion.
//  Sits between the periodic enable generator and the board pin.
// PARAMETERS
//  UNIT_CYC   2_500_000  clock cycles per Morse time unit (50 ms at 50 MHz); legal range 2..2^26
// PORTS
//  CLK         in   1  system clock; only clock
//  RST         in   1  synchronous, active-high reset
//  SOS_En_Sig  in   1  1-cycle trigger pulse from the enable generator
//  Pin_Out     out  1  Morse output, 1 = mark (tone/LED on)
//  Busy_Sig    out  1  high while a sequence is playing
//  Done_Sig    out  1  1-cycle pulse when a sequence completes
// BEHAVIOUR
//  - Reset (RST=1 at a CLK edge): Pin_Out=0, Busy_Sig=0, Done_Sig=0, FSM=IDLE, counters=0, pending=0.
//    Reset mid-sequence aborts immediately; no Done_Sig is produced.
//  - All outputs registered. Symbol table (index 0..8): D D D H H H D D D (D=dot, H=dash).
//  - Timing: dot mark = 1 unit, dash mark = 3 units, gap inside a letter = 1 unit,
//    gap between letters (after symbol 2 and 5) = 3 units, no trailing gap. Total = 27 units.
//  - FSM: IDLE -> MARK -> GAP -> MARK ... ; after the last cycle of symbol 8 MARK -> IDLE.
//    IDLE : SOS_En_Sig=1 at edge t -> MARK, sym=0; Pin_Out=1, Busy_Sig=1 from cycle t+1.
//    MARK : hold Pin_Out=1 for exactly len(sym)*UNIT_CYC cycles; then GAP (sym<8) or IDLE (sym=8).
//    GAP  : Pin_Out=0 for 1 or 3 units exactly; then MARK with sym+1.
//  - Done_Sig=1 and Busy_Sig=0 in the first IDLE cycle after symbol 8; Pin_Out=0 there.
//  - Trigger during MARK/GAP: ignored (see CONFIGURATION). Trigger in the Done_Sig cycle is
//    accepted (FSM already IDLE): next sequence starts Pin_Out=1 at the following cycle.
//  - Unit counter width = $clog2(3*UNIT_CYC); counts 0..len*UNIT_CYC-1, clears on every state
//    change; never wraps inside a phase. Symbol index 4 bits, saturates/clears on IDLE.
//  - Latency trigger->first mark edge: 1 cycle. Sequence length: 27*UNIT_CYC cycles of Busy_Sig.
// CONFIGURATION
//  SOS_PENDING_TRIG_EN defined: a trigger arriving while Busy_Sig=1 sets a 1-deep pending flag
//   (further triggers while set are dropped). In the Done_Sig cycle, pending clears and the next
//   sequence starts as if SOS_En_Sig were high that cycle. RST clears pending.
//  Not defined: triggers while Busy_Sig=1 are discarded; no pending register is built.
// TESTING (UNIT_CYC=4, trigger at cycle 0, cycles relative)
//  1 Reset: RST=1 with SOS_En_Sig toggling -> Pin_Out=Busy_Sig=Done_Sig=0 throughout.
//  2 Single trigger -> Pin_Out high in cycles 1-4, 9-12, 17-20, 33-44, 49-60, 65-76, 89-92,
//    97-100, 105-108, low elsewhere; Busy_Sig 1-108; Done_Sig only at cycle 109.
//  3 Trigger at cycle 50 (mid-dash) -> waveform identical to test 2; without macro no second
//    sequence; with SOS_PENDING_TRIG_EN second sequence Pin_Out high from cycle 110.
//  4 Trigger exactly at cycle 109 (Done_Sig cycle) -> second sequence, Pin_Out high cycles 110-113.
//  5 RST=1 at cycle 40 for 1 cycle -> Pin_Out=Busy_Sig=0 from 41, no Done_Sig; new trigger at
//    cycle 60 replays test 2 shifted by 60.
//  6 UNIT_CYC=2_500_000 @50 MHz, trigger every 150_000_000 cycles -> Busy_Sig 67_500_000 cycles,
//    one Done_Sig per trigger, no overlap.

Source files
------------

// File: rtl/sos_morse_player_if.sv
// Trigger/status bundle between the SOS enable generator, the Morse player and the pin.
// The generator side drives the trigger; the player side drives the pin and the status flags.
interface sos_morse_player_if;
    logic SOS_En_Sig;
    logic Pin_Out;
    logic Busy_Sig;
    logic Done_Sig;

    modport master (output SOS_En_Sig, input Pin_Out, Busy_Sig, Done_Sig);
    modport slave  (input SOS_En_Sig, output Pin_Out, Busy_Sig, Done_Sig);
endinterface

// File: rtl/sos_morse_player.sv
// Plays one Morse "SOS" (... --- ...) on Pin_Out per accepted trigger, then pulses Done_Sig.
// Latency: trigger to first mark is 1 cycle; a sequence keeps Busy_Sig high for 27*UNIT_CYC cycles.
// Backpressure: none. Triggers while busy are dropped, or held 1-deep when SOS_PENDING_TRIG_EN is defined.
module sos_morse_player #(
    parameter int UNIT_CYC = 2_500_000
) (
    input  logic                CLK,
    input  logic                RST,
    sos_morse_player_if.slave   io
);
    localparam int CW = $clog2(3 * UNIT_CYC);
    localparam logic [CW-1:0] LAST_1 = CW'(UNIT_CYC - 1);
    localparam logic [CW-1:0] LAST_3 = CW'(3 * UNIT_CYC - 1);

    typedef enum logic [1:0] {IDLE, MARK, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    sym_q, sym_d;
    logic          pin_q, busy_q, done_q, done_d;
    logic          start;
    logic          long_phase;
    logic          phase_end;

    // Dashes are symbols 3..5; the letter gaps follow symbols 2 and 5.
    always_comb begin
        long_phase = 1'b0;
        if (state_q == MARK)
            long_phase = (sym_q >= 4'd3) && (sym_q <= 4'd5);
        else if (state_q == GAP)
            long_phase = (sym_q == 4'd2) || (sym_q == 4'd5);
        phase_end = (cnt_q == (long_phase ? LAST_3 : LAST_1));
    end

`ifdef SOS_PENDING_TRIG_EN
    logic pend_q, pend_d;

    assign start = io.SOS_En_Sig | pend_q;

    // Leaving IDLE consumes the pending request; while busy a trigger is remembered once.
    always_comb begin
        pend_d = pend_q;
        if (state_q == IDLE)
            pend_d = 1'b0;
        else if (io.SOS_En_Sig)
            pend_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) pend_q <= 1'b0;
        else     pend_q <= pend_d;
    end
`else
    assign start = io.SOS_En_Sig;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        sym_d   = sym_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                sym_d = 4'd0;
                if (start) state_d = MARK;
            end
            MARK: begin
                if (phase_end) begin
                    cnt_d = '0;
                    if (sym_q == 4'd8) begin
                        state_d = IDLE;
                        sym_d   = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (phase_end) begin
                    cnt_d   = '0;
                    state_d = MARK;
                    sym_d   = sym_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                sym_d   = 4'd0;
            end
        endcase
    end

    // Outputs are flopped from the next state so they line up with the state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sym_q   <= 4'd0;
            pin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            pin_q   <= (state_d == MARK);
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
        end
    end

    assign io.Pin_Out  = pin_q;
    assign io.Busy_Sig = busy_q;
    assign io.Done_Sig = done_q;
endmodule

// File: tb/tb_sos_morse_player.sv
// Directed bench for sos_morse_player: per-cycle {RST, trigger, expected pin/busy/done} tables plus a
// short UNIT_CYC=2 sequence on a second instance.
module tb_sos_morse_player;
    localparam int U   = 4;
    localparam int SEQ = 27 * U;
    localparam int N   = 230;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    sos_morse_player_if bus ();
    sos_morse_player_if bus2 ();

    sos_morse_player #(.UNIT_CYC(U)) dut  (.CLK(CLK), .RST(RST), .io(bus.slave));
    sos_morse_player #(.UNIT_CYC(2)) dut2 (.CLK(CLK), .RST(RST), .io(bus2.slave));

    // pbd = {Pin_Out, Busy_Sig, Done_Sig}
    typedef struct {int lo; int hi; logic [2:0] pbd;} seg_t;
    typedef struct {bit rst; bit en; logic [2:0] pbd;} step_t;

    seg_t       segs [19];
    logic [2:0] tmpl [0:SEQ+1];
    step_t      vec  [N];
    int         n_pass  = 0;
    int         n_total = 0;

    task automatic chk(input string name, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d want %0d", name, got, want);
    endtask

    task automatic clear_vec();
        for (int i = 0; i < N; i++) vec[i] = '{1'b0, 1'b0, 3'b000};
    endtask

    task automatic overlay(input int base, input int limit);
        for (int k = 1; k <= SEQ + 1; k++)
            if (base + k <= limit && base + k < N) vec[base + k].pbd = tmpl[k];
    endtask

    task automatic run(input string name);
        logic [2:0] got;
        for (int c = 0; c < N; c++) begin
            @(negedge CLK);
            got = {bus.Pin_Out, bus.Busy_Sig, bus.Done_Sig};
            n_total++;
            if (got === vec[c].pbd) n_pass++;
            else $display("FAIL %s cycle %0d: pin/busy/done got %b want %b", name, c, got, vec[c].pbd);
            RST            = vec[c].rst;
            bus.SOS_En_Sig = vec[c].en;
        end
    endtask

    initial begin
        int busy_cnt, pin_cnt, done_cnt, done_at, first_pin;

        segs = '{'{0, 0, 3'b000},
                 '{1, 4, 3'b110},   '{5, 8, 3'b010},   '{9, 12, 3'b110},  '{13, 16, 3'b010},
                 '{17, 20, 3'b110}, '{21, 32, 3'b010}, '{33, 44, 3'b110}, '{45, 48, 3'b010},
                 '{49, 60, 3'b110}, '{61, 64, 3'b010}, '{65, 76, 3'b110}, '{77, 88, 3'b010},
                 '{89, 92, 3'b110}, '{93, 96, 3'b010}, '{97, 100, 3'b110}, '{101, 104, 3'b010},
                 '{105, 108, 3'b110}, '{109, 109, 3'b001}};
        for (int s = 0; s < 19; s++)
            for (int k = segs[s].lo; k <= segs[s].hi; k++) tmpl[k] = segs[s].pbd;

        RST             = 1'b1;
        bus.SOS_En_Sig  = 1'b0;
        bus2.SOS_En_Sig = 1'b0;
        repeat (3) @(negedge CLK);

        // Reset held with the trigger toggling
        clear_vec();
        for (int c = 0; c < 20; c++) begin
            vec[c].rst = 1'b1;
            vec[c].en  = c[0];
        end
        run("reset_hold");

        clear_vec();
        vec[0].en = 1'b1;
        overlay(0, N);
        run("single");

        clear_vec();
        vec[0].en  = 1'b1;
        vec[50].en = 1'b1;
        overlay(0, N);
`ifdef SOS_PENDING_TRIG_EN
        overlay(109, N);
`endif
        run("busy_trig");

        clear_vec();
        vec[0].en   = 1'b1;
        vec[109].en = 1'b1;
        overlay(0, N);
        overlay(109, N);
        run("done_cycle_trig");

        clear_vec();
        vec[0].en   = 1'b1;
        vec[40].rst = 1'b1;
        overlay(0, 40);
        vec[60].en  = 1'b1;
        overlay(60, N);
        run("mid_reset");

        // Smallest legal unit: 54 busy cycles, 15 mark units of 2 cycles, Done at cycle 55
        busy_cnt = 0; pin_cnt = 0; done_cnt = 0; done_at = -1; first_pin = -1;
        @(negedge CLK);
        bus2.SOS_En_Sig = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            @(negedge CLK);
            bus2.SOS_En_Sig = 1'b0;
            if (bus2.Busy_Sig === 1'b1) busy_cnt++;
            if (bus2.Pin_Out === 1'b1) begin
                pin_cnt++;
                if (first_pin < 0) first_pin = c;
            end
            if (bus2.Done_Sig === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
        end
        chk("u2_first_pin", first_pin, 1);
        chk("u2_busy_cycles", busy_cnt, 54);
        chk("u2_pin_cycles", pin_cnt, 30);
        chk("u2_done_count", done_cnt, 1);
        chk("u2_done_cycle", done_at, 55);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
